wc_io_sequencer: RTL and testbench

- Controller between the pin-limited 10-bit chip I/O and the WC_4_3 Winograd F(4x4,3x3) core.
- Parses a word-serial command stream on D and writes 9 kernel weights and 36 input-tile words into the core.
- Starts the core, waits for completion with a timeout, then streams the 16 output words onto Z.
- Sits between the pad ring and WC_4_3 inside the chip top.

---
 rtl/wc_seq_pkg.sv | 49 ++++
 rtl/wc_seq_cnt.sv | 35 +++
 rtl/wc_io_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_wc_io_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wc_seq_pkg.sv
// wc_seq_pkg: shared types and constants for the WC_4_3 I/O sequencer.
//   - state_t      : sequencer FSM states
//   - OP_*         : opcode field D[1:0] of a header word
//   - HDR_TAG      : D[9:8] value that marks a header word in IDLE
//   - ST_*         : bit positions inside the STATUS word
//   - status_word(): packs the sticky flags and frame counter
package wc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_LOADX,
    S_START,
    S_WAIT,
    S_READ,
    S_STAT
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDW  = 2'b01;
  localparam logic [1:0] OP_LDX  = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;

  localparam logic [1:0] HDR_TAG = 2'b10;

  localparam int ST_ERR_TO    = 9;
  localparam int ST_ERR_NW    = 8;
  localparam int ST_W_LOADED  = 7;
  localparam int ST_FRAME_LSB = 0;

  // Width of the shared index/timeout counter; must hold TO_CYC-1 and NX-1.
  localparam int CW = 8;

  function automatic logic [9:0] status_word(
    input logic       err_to,
    input logic       err_nw,
    input logic       w_loaded,
    input logic [5:0] frame_cnt
  );
    logic [9:0] w;
    w = '0;
    w[ST_ERR_TO]                     = err_to;
    w[ST_ERR_NW]                     = err_nw;
    w[ST_W_LOADED]                   = w_loaded;
    w[ST_FRAME_LSB+5:ST_FRAME_LSB]   = frame_cnt;
    return w;
  endfunction

endpackage

// File: rtl/wc_seq_cnt.sv
// wc_seq_cnt: loadable up-counter with terminal-count flag.
//   clk, rst   : clock, async active-low reset
//   load       : synchronous load of load_val (priority over en)
//   load_val   : value loaded on load
//   en         : increment enable
//   last       : terminal value; tc=1 while cnt==last
//   cnt, tc    : current count and terminal-count flag
module wc_seq_cnt
  import wc_seq_pkg::*;
#(
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/wc_io_sequencer.sv
// wc_io_sequencer: bridges the word-serial pad interface (D/Z) and the
// WC_4_3 Winograd core. Parses headers, loads weights and the input tile,
// starts the core, waits for done with a timeout, streams the output tile.
//   clk, rst        : clock, async active-low reset
//   D               : command/data word, sampled every cycle
//   Z, z_vld        : output data/status word and its valid flag
//   core_w_we/addr  : weight write strobe and index
//   core_x_we/addr  : input-tile write strobe and index
//   core_wr_data    : shared write data (registered D)
//   core_start      : one-cycle compute pulse
//   core_done       : core completion (level or pulse)
//   core_y_addr     : output read index
//   core_y_data     : output read data, one cycle after core_y_addr
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a header word (D[9:8]==HDR_TAG)
// S_LOADW | consuming NW weight words, writing them to the core
// S_LOADX | consuming NX tile words; writes only if weights are loaded
// S_START | pulse core_start, clear the timeout counter
// S_WAIT  | waiting for core_done or timeout
// S_READ  | issuing NY read addresses and draining the read pipeline
// S_STAT  | emitting the status word, clearing sticky errors
module wc_io_sequencer
  import wc_seq_pkg::*;
#(
  parameter int DW     = 10,
  parameter int NW     = 9,
  parameter int NX     = 36,
  parameter int NY     = 16,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Z,
  output logic          z_vld,
  output logic          core_w_we,
  output logic [3:0]    core_w_addr,
  output logic          core_x_we,
  output logic [5:0]    core_x_addr,
  output logic [DW-1:0] core_wr_data,
  output logic          core_start,
  input  logic          core_done,
  output logic [3:0]    core_y_addr,
  input  logic [DW-1:0] core_y_data
);

  state_t       state;
  logic         w_loaded;
  logic         err_to;
  logic         err_nw;
  logic [5:0]   frame_cnt;

  // Read pipeline: y_req marks a cycle with a valid core_y_addr,
  // y_data_vld marks the following cycle when core_y_data is valid.
  logic         y_req;
  logic         y_data_vld;

  logic         cnt_load;
  logic         cnt_en;
  logic [CW-1:0] cnt_last;
  logic [CW-1:0] cnt;
  logic         cnt_tc;

  wc_seq_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .last     (cnt_last),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // One counter serves every state: load index, timeout, read index.
  // States that do not count hold it at zero so the next counting state
  // starts from index 0 without an extra cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_last = '0;
    case (state)
      S_LOADW: begin
        cnt_en   = 1'b1;
        cnt_last = CW'(NW - 1);
      end
      S_LOADX: begin
        cnt_en   = 1'b1;
        cnt_last = CW'(NX - 1);
      end
      S_WAIT: begin
        cnt_last = CW'(TO_CYC - 1);
        if (core_done) cnt_load = 1'b1;
        else           cnt_en   = 1'b1;
      end
      S_READ: begin
        // Runs to NY so the last two words leave the pipeline before IDLE.
        cnt_en   = 1'b1;
        cnt_last = CW'(NY);
      end
      default: cnt_load = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      w_loaded     <= 1'b0;
      err_to       <= 1'b0;
      err_nw       <= 1'b0;
      frame_cnt    <= '0;
      y_req        <= 1'b0;
      y_data_vld   <= 1'b0;
      Z            <= '0;
      z_vld        <= 1'b0;
      core_w_we    <= 1'b0;
      core_w_addr  <= '0;
      core_x_we    <= 1'b0;
      core_x_addr  <= '0;
      core_wr_data <= '0;
      core_start   <= 1'b0;
      core_y_addr  <= '0;
    end else begin
      core_w_we  <= 1'b0;
      core_x_we  <= 1'b0;
      core_start <= 1'b0;
      z_vld      <= 1'b0;
      y_req      <= 1'b0;
      y_data_vld <= y_req;

      if (y_data_vld) begin
        z_vld <= 1'b1;
        Z     <= core_y_data;
      end

      case (state)
        S_IDLE: begin
          if (D[DW-1:DW-2] == HDR_TAG) begin
            case (D[1:0])
              OP_NOP:  state <= S_IDLE;
              OP_LDW:  state <= S_LOADW;
              OP_LDX:  state <= S_LOADX;
              OP_STAT: state <= S_STAT;
              default: state <= S_IDLE;
            endcase
          end
        end

        S_LOADW: begin
          core_w_we    <= 1'b1;
          core_w_addr  <= cnt[3:0];
          core_wr_data <= D;
          if (cnt_tc) begin
            w_loaded <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_LOADX: begin
          // Without weights the words are still consumed to keep framing.
          if (w_loaded) begin
            core_x_we    <= 1'b1;
            core_x_addr  <= cnt[5:0];
            core_wr_data <= D;
          end
          if (cnt_tc) begin
            if (w_loaded) begin
              state <= S_START;
            end else begin
              err_nw <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end

        S_START: begin
          core_start <= 1'b1;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          // done is tested first so it wins over a same-cycle timeout
          if (core_done) begin
            y_req       <= 1'b1;
            core_y_addr <= '0;
            state       <= S_READ;
          end else if (cnt_tc) begin
            err_to <= 1'b1;
            state  <= S_IDLE;
          end
        end

        S_READ: begin
          if (cnt < CW'(NY - 1)) begin
            y_req       <= 1'b1;
            core_y_addr <= cnt[3:0] + 4'd1;
          end
          if (cnt_tc) begin
            frame_cnt <= frame_cnt + 6'd1;
            state     <= S_IDLE;
          end
        end

        S_STAT: begin
          z_vld  <= 1'b1;
          Z      <= DW'(status_word(err_to, err_nw, w_loaded, frame_cnt));
          err_to <= 1'b0;
          err_nw <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wc_io_sequencer.sv
`timescale 1ns/1ps
module tb_wc_io_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] D = '0;
  logic [9:0] Z;
  logic       z_vld;
  logic       core_w_we;
  logic [3:0] core_w_addr;
  logic       core_x_we;
  logic [5:0] core_x_addr;
  logic [9:0] core_wr_data;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] core_y_addr;
  logic [9:0] core_y_data = '0;

  always #5 clk = ~clk;

  wc_io_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .D            (D),
    .Z            (Z),
    .z_vld        (z_vld),
    .core_w_we    (core_w_we),
    .core_w_addr  (core_w_addr),
    .core_x_we    (core_x_we),
    .core_x_addr  (core_x_addr),
    .core_wr_data (core_wr_data),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_y_addr  (core_y_addr),
    .core_y_data  (core_y_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  // Core model: registered read y[i]=0x300+i; core_done pulses in the
  // cycle done_after cycles after the cycle core_start is high (0 = never).
  int done_after = 0;
  int wc = 0;
  always @(posedge clk) begin : core_model
    int jcur;
    core_y_data <= 10'h300 + {6'd0, core_y_addr};
    if (core_start)  jcur = 1;
    else if (wc > 0) jcur = wc + 1;
    else             jcur = 0;
    wc <= jcur;
    core_done <= (done_after > 0) && (jcur == done_after);
  end

  // Scoreboard: every valid Z word must match the head of the queue.
  always @(negedge clk) begin : z_monitor
    logic [9:0] e;
    if (rst && z_vld) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL z_unexpected: got Z=%h with z_vld=1, required no output word", Z);
      end else begin
        e = exp_q.pop_front();
        if (Z !== e) begin
          n_err++;
          $display("FAIL z_word: got %h required %h", Z, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] d);
    D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".Z"},            Z,            0);
    chk({tag, ".z_vld"},        z_vld,        0);
    chk({tag, ".w_we"},         core_w_we,    0);
    chk({tag, ".w_addr"},       core_w_addr,  0);
    chk({tag, ".x_we"},         core_x_we,    0);
    chk({tag, ".x_addr"},       core_x_addr,  0);
    chk({tag, ".wr_data"},      core_wr_data, 0);
    chk({tag, ".start"},        core_start,   0);
    chk({tag, ".y_addr"},       core_y_addr,  0);
  endtask

  // One record per cycle: D driven, and outputs expected after the edge
  // that samples it. zcnt words zbase, zbase+1.. are queued at drive time.
  typedef struct {
    logic [9:0] d;
    logic       ww;
    logic [3:0] wa;
    logic       xw;
    logic [5:0] xa;
    logic [9:0] wd;
    logic       st;
    int         zcnt;
    logic [9:0] zbase;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [9:0] d, input logic ww, input logic [3:0] wa,
                     input logic xw, input logic [5:0] xa, input logic [9:0] wd,
                     input logic st, input int zcnt, input logic [9:0] zbase);
    tbl.push_back('{d, ww, wa, xw, xa, wd, st, zcnt, zbase});
  endtask

  task automatic fill(input logic [9:0] d);
    add(d, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_ldx_run();
    step(10'h202);
    for (int i = 0; i < 36; i++) step(10'(704 + i));
    step(10'h000);
    chk("run_start_pulse", core_start, 1);
  endtask

  initial begin
    vec_t v;

    // LOAD_X_RUN with no weights: consumed silently, err_nw set
    fill(10'h202);
    for (int i = 0; i < 36; i++) fill(10'(704 + i));
    add(10'h203, 0, 0, 0, 0, 0, 0, 1, 10'h100);
    fill(10'h000); fill(10'h000);
    add(10'h203, 0, 0, 0, 0, 0, 0, 1, 10'h000);
    fill(10'h000); fill(10'h000);
    // LOAD_W 1..9 then STATUS
    fill(10'h201);
    for (int k = 1; k <= 9; k++) add(10'(k), 1, 4'(k - 1), 0, 0, 10'(k), 0, 0, 0);
    add(10'h203, 0, 0, 0, 0, 0, 0, 1, 10'h080);
    fill(10'h000); fill(10'h000);
    // Full frame: core done 20 cycles after start
    add(10'h202, 0, 0, 0, 0, 0, 0, 16, 10'h300);
    for (int i = 0; i < 36; i++) add(10'(704 + i), 0, 0, 1, 6'(i), 10'(704 + i), 0, 0, 0);
    add(10'h000, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 45; i++) fill(10'h000);
    add(10'h203, 0, 0, 0, 0, 0, 0, 1, 10'h081);
    fill(10'h000); fill(10'h000);

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b1;
    done_after = 20;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      for (int k = 0; k < v.zcnt; k++) exp_q.push_back(v.zbase + 10'(k));
      step(v.d);
      chk($sformatf("w_we@%0d", i), core_w_we, v.ww);
      if (v.ww) begin
        chk($sformatf("w_addr@%0d", i), core_w_addr, v.wa);
        chk($sformatf("w_data@%0d", i), core_wr_data, v.wd);
      end
      chk($sformatf("x_we@%0d", i), core_x_we, v.xw);
      if (v.xw) begin
        chk($sformatf("x_addr@%0d", i), core_x_addr, v.xa);
        chk($sformatf("x_data@%0d", i), core_wr_data, v.wd);
      end
      chk($sformatf("start@%0d", i), core_start, v.st);
    end

    // Timeout: core never finishes; 255 WAIT cycles then IDLE
    done_after = 0;
    send_ldx_run();
    step(10'h000);
    chk("to_start_single", core_start, 0);
    for (int e = 2; e <= 255; e++) step(10'h000);
    exp_q.push_back(10'h281);
    step(10'h203);
    step(10'h000);
    step(10'h000);

    // core_done exactly on the terminal-count cycle: done wins
    done_after = 254;
    for (int k = 0; k < 16; k++) exp_q.push_back(10'h300 + 10'(k));
    send_ldx_run();
    for (int e = 1; e <= 275; e++) begin
      step(10'h000);
      chk($sformatf("tc_zvld@%0d", e), z_vld, (e >= 257 && e <= 272));
    end
    exp_q.push_back(10'h082);
    step(10'h203);
    step(10'h000);
    step(10'h000);

    // Reset during LOAD_X_RUN word 10
    done_after = 0;
    step(10'h202);
    for (int i = 0; i < 10; i++) step(10'(704 + i));
    chk("pre_rst_x_we", core_x_we, 1);
    chk("pre_rst_x_addr", core_x_addr, 9);
    #1 rst = 1'b0;
    #1 chk_quiet("rst_async");
    step(10'h2C5);
    chk_quiet("rst_hold");
    rst = 1'b1;
    step(10'h123);
    chk("post_rst_w_we", core_w_we, 0);
    chk("post_rst_x_we", core_x_we, 0);
    step(10'h2C0);
    chk("post_rst_nop_x_we", core_x_we, 0);
    exp_q.push_back(10'h000);
    step(10'h203);
    step(10'h000);
    step(10'h000);
    step(10'h000);

    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
